mdu_iterative: RTL and testbench
================================

Name: mdu_iterative

Overview:
- Multi-cycle RV32M multiply/divide unit in the execute stage.
- Consumes the two operands read from the register file (readOut1/readOut2 path) plus the destination register tag.
- Produces a 32-bit result and tag for the writeback path, which drives the register file write port (dataIn, rd, writeEn).
- Radix-2 iterative datapath with valid/ready handshakes on both sides, so the pipeline stalls while it is busy.

Parameters:
- XLEN, 32, operand/result width.
- TAG_W, 5, destination-register tag width.
- CALC_CYCLES, 32, iteration count; always equals XLEN.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- in_valid  in  1  operation request
- in_ready  out  1  unit can accept a request
- op  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- a  in  XLEN  rs1 operand
- b  in  XLEN  rs2 operand
- tag_in  in  TAG_W  rd of the instruction
- out_valid  out  1  result available
- out_ready  in  1  writeback accepts result
- result  out  XLEN  result value
- tag_out  out  TAG_W  rd for writeback
- busy  out  1  high in any state except IDLE

Behaviour:
- Clock and reset: clk is the clock; reset is synchronous, active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, result=0, tag_out=0, all internal registers 0.
- Request accept: when in_valid&&in_ready at a rising edge, latch op, a, b and tag_in; go to PREP. Inputs are ignored in every other state.
- IDLE: in_ready=1. Transition to PREP on accept.
- PREP (1 cycle):
  - Signed ops (MULH, DIV, REM; a only for MULHSU): take absolute values and record the result sign.
  - Result sign: product sign = sa^sb; quotient sign = sa^sb; remainder sign = sa.
  - Clear the 64-bit accumulator and set iteration counter=0.
- CALC (CALC_CYCLES cycles):
  - Multiply: shift-add, one multiplier bit per cycle, LSB first, into the 64-bit accumulator.
  - Divide: restoring shift-subtract, one quotient bit per cycle, MSB first.
  - Counter increments each cycle; exit to FIX when counter==CALC_CYCLES-1.
- FIX (1 cycle):
  - Negate the magnitude if the result sign is set.
  - Select the output word: MUL low 32 bits; MULH/MULHSU/MULHU high 32 bits; DIV/DIVU quotient; REM/REMU remainder.
  - Register into result and tag_out; go to DONE.
- DONE: out_valid=1. result and tag_out held stable until out_ready is high at an edge, then go to IDLE. in_ready stays 0 while in DONE; no bypass of a new request.
- Latency: fixed. out_valid rises 34 edges after the accept edge (PREP 1 + CALC 32 + FIX 1), for every op including special cases.
- Divide by zero (b==0):
  - DIV/DIVU → 0xFFFFFFFF.
  - REM/REMU → a.
  - No exception; decided in PREP and forced in FIX.
- Signed overflow (DIV/REM, a=0x80000000, b=0xFFFFFFFF): DIV → 0x80000000, REM → 0.
- Magnitude of 0x80000000: must be handled as unsigned 2^31 (33-bit internal negate), not saturated.
- Reset mid-operation: abort in any state; the next cycle is IDLE with reset values. No partial result is ever presented.
- out_ready high outside DONE: no effect.

Decomposition:
- Package mdu_pkg holds:
  - XLEN and CALC_CYCLES constants.
  - mdu_op_e enum with the funct3 codes above.
  - mdu_state_e enum: IDLE, PREP, CALC, FIX, DONE.
- The FSM stays in the top module.
- One sub-module is natural: mdu_step, a combinational single-iteration step (add-or-pass for multiply, subtract-or-restore for divide) selected by an is_div input, instantiated once.

Test Plan:
- MUL, a=7, b=0xFFFFFFFD, tag=5 → result 0xFFFFFFEB, tag_out 5, out_valid exactly 34 edges after accept.
- MULH, a=b=0x80000000 → 0x40000000. MULHU, a=b=0xFFFFFFFF → 0xFFFFFFFE. MULHSU, a=0xFFFFFFFF, b=2 → 0xFFFFFFFF.
- DIVU 100/7 → 14. REMU 100%7 → 2. DIV 0xFFFFFFF9/2 → 0xFFFFFFFD. REM 0xFFFFFFF9%2 → 0xFFFFFFFF.
- Divide by zero: DIV 1234/0 → 0xFFFFFFFF; REM 1234/0 → 1234. Overflow: DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM of the same → 0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → result/tag stable, in_ready=0, a new in_valid is not accepted; out_ready=1 → IDLE and in_ready=1 on the next cycle.
- Reset asserted on CALC cycle 10 → next cycle in_ready=1, busy=0, out_valid=0, result=0; a following MUL 3*4 → 12 with normal latency.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit.
//   XLEN, TAG_W, CALC_CYCLES : default widths and iteration count
//   mdu_op_e                 : funct3 encodings of the M-extension ops
//   mdu_state_e              : control FSM states
//   op_signed_a/op_signed_b  : which operands are treated as two's complement
//   op_is_rem                : remainder ops take the sign of the dividend only
package mdu_pkg;

  localparam int XLEN        = 32;
  localparam int TAG_W       = 5;
  localparam int CALC_CYCLES = XLEN;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } mdu_op_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    CALC = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } mdu_state_e;

  // MUL only uses the low product word, which is sign-agnostic, so it runs unsigned.
  function automatic logic op_signed_a(input mdu_op_e op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic op_signed_b(input mdu_op_e op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic op_is_rem(input mdu_op_e op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/mdu_step.sv
// One radix-2 iteration of the multiply/divide datapath (purely combinational).
//   is_div   : 1 = restoring shift-subtract, 0 = shift-add
//   acc      : 2*XLEN accumulator {high, low}
//   operand  : multiplicand (multiply) or divisor magnitude (divide)
//   bit_in   : current multiplier bit (LSB first) or dividend bit (MSB first)
//   acc_next : accumulator after this iteration
// Multiply: high half += operand when bit_in is set, then the whole
//   accumulator shifts right with the carry entering at the top.
// Divide: high half is the partial remainder, low half collects quotient bits.
module mdu_step #(
  parameter int XLEN = 32
) (
  input  logic              is_div,
  input  logic [2*XLEN-1:0] acc,
  input  logic [XLEN-1:0]   operand,
  input  logic              bit_in,
  output logic [2*XLEN-1:0] acc_next
);

  logic [XLEN:0] sum;
  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  // NOTE: every signal driven here gets a value on every path, starting with
  // defaults, so no latch is inferred for the unselected branch.
  always_comb begin
    sum      = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (bit_in ? operand : '0)};
    shifted  = {acc[2*XLEN-1:XLEN], bit_in};
    diff     = shifted - {1'b0, operand};
    acc_next = acc;
    if (is_div) begin
      // The partial remainder stays below the divisor, so a borrow out of the
      // top bit is exactly "shifted < divisor": restore and record a 0 bit.
      if (!diff[XLEN]) acc_next = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
      else             acc_next = {shifted[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    end else begin
      acc_next = {sum, acc[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/mdu_iterative.sv
// Iterative RV32M multiply/divide unit for the execute stage.
//   clk, reset          : clock, synchronous active-high reset
//   in_valid/in_ready   : request handshake (op, a, b, tag_in latched on accept)
//   op                  : funct3 of the M-extension instruction
//   a, b                : rs1 / rs2 operands
//   tag_in              : destination register of the instruction
//   out_valid/out_ready : result handshake towards writeback
//   result, tag_out     : registered result word and its destination register
//   busy                : unit is occupied (any state but IDLE)
// Sequence: IDLE -> PREP (magnitudes, signs) -> CALC (CALC_CYCLES iterations)
// -> FIX (sign fix-up, word select) -> DONE (hold until out_ready).
// Latency is fixed for every op, including divide-by-zero and overflow.
module mdu_iterative #(
  parameter int XLEN        = mdu_pkg::XLEN,
  parameter int TAG_W       = mdu_pkg::TAG_W,
  parameter int CALC_CYCLES = mdu_pkg::CALC_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [XLEN-1:0]  a,
  input  logic [XLEN-1:0]  b,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  result,
  output logic [TAG_W-1:0] tag_out,
  output logic             busy
);

  import mdu_pkg::*;

  localparam int CNT_W = (CALC_CYCLES > 1) ? $clog2(CALC_CYCLES) : 1;

  mdu_state_e        state_q, state_d;
  mdu_op_e           op_q;
  logic [XLEN-1:0]   a_q, b_q;
  logic [TAG_W-1:0]  tag_q;
  logic [2*XLEN-1:0] acc_q, acc_next;
  logic [CNT_W-1:0]  cnt_q;
  logic              neg_q, div0_q;
  logic [XLEN-1:0]   result_q;
  logic [TAG_W-1:0]  tag_out_q;

  logic              is_div;
  logic              sa, sb;
  logic [XLEN:0]     a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic              calc_last;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem;
  logic [XLEN-1:0]   fix_word;

  assign is_div    = op_q[2];
  assign calc_last = (cnt_q == CNT_W'(CALC_CYCLES - 1));

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign result    = result_q;
  assign tag_out   = tag_out_q;

  // ---------------------------------------------------------------- FSM
  // NOTE: reset here is synchronous: it is sampled only on the clock edge, so
  // it sits inside the clocked block rather than in the sensitivity list.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid) state_d = PREP;
      PREP:    state_d = CALC;
      CALC:    if (calc_last) state_d = FIX;
      FIX:     state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------- PREP
  // Magnitudes use a one-bit-wider negate so 0x80000000 becomes unsigned 2^31.
  always_comb begin
    sa    = op_signed_a(op_q) && a_q[XLEN-1];
    sb    = op_signed_b(op_q) && b_q[XLEN-1];
    a_neg = -{a_q[XLEN-1], a_q};
    b_neg = -{b_q[XLEN-1], b_q};
    a_mag = sa ? a_neg[XLEN-1:0] : a_q;
    b_mag = sb ? b_neg[XLEN-1:0] : b_q;
  end

  // ---------------------------------------------------------------- CALC
  // Multiply consumes b LSB first (b shifts right); divide consumes a MSB first
  // (a shifts left). The constant operand feeds the step unchanged.
  mdu_step #(.XLEN(XLEN)) u_step (
    .is_div   (is_div),
    .acc      (acc_q),
    .operand  (is_div ? b_q : a_q),
    .bit_in   (is_div ? a_q[XLEN-1] : b_q[0]),
    .acc_next (acc_next)
  );

  // ---------------------------------------------------------------- FIX
  always_comb begin
    prod     = neg_q ? -acc_q : acc_q;
    quo      = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem      = neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    fix_word = '0;
    unique case (op_q)
      OP_MUL:                         fix_word = prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:   fix_word = prod[2*XLEN-1:XLEN];
      // A zero divisor yields an all-ones quotient regardless of operand sign.
      OP_DIV, OP_DIVU:                fix_word = div0_q ? '1 : quo;
      // The restoring loop leaves |a| as remainder for a zero divisor, and the
      // dividend sign restores a itself.
      OP_REM, OP_REMU:                fix_word = rem;
      default:                        fix_word = '0;
    endcase
  end

  // ---------------------------------------------------------------- datapath
  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q      <= OP_MUL;
      a_q       <= '0;
      b_q       <= '0;
      tag_q     <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      div0_q    <= 1'b0;
      result_q  <= '0;
      tag_out_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: if (in_valid) begin
          op_q  <= mdu_op_e'(op);
          a_q   <= a;
          b_q   <= b;
          tag_q <= tag_in;
        end
        PREP: begin
          a_q    <= a_mag;
          b_q    <= b_mag;
          neg_q  <= op_is_rem(op_q) ? sa : (sa ^ sb);
          div0_q <= (b_q == '0);
          acc_q  <= '0;
          cnt_q  <= '0;
        end
        CALC: begin
          acc_q <= acc_next;
          cnt_q <= cnt_q + 1'b1;
          if (is_div) a_q <= a_q << 1;
          else        b_q <= b_q >> 1;
        end
        FIX: begin
          result_q  <= fix_word;
          tag_out_q <= tag_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iterative.sv
module tb_mdu_iterative;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic [4:0]  tag_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [4:0]  tag_out;
  logic        busy;

  int n_cmp  = 0;
  int n_fail = 0;

  localparam int LATENCY = 34;
  localparam int TIMEOUT = 100;

  mdu_iterative dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .tag_in    (tag_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .tag_out   (tag_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  tag;
    logic [31:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue one request from IDLE and wait for out_valid, counting edges after
  // the accept edge. Leaves the unit in DONE with out_ready low.
  task automatic start_and_wait(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                input logic [4:0] t, output int lat);
    @(negedge clk);
    in_valid = 1'b1; op = o; a = x; b = y; tag_in = t;
    @(posedge clk); #1;
    in_valid = 1'b0; op = 3'd0; a = '0; b = '0; tag_in = '0;
    lat = 0;
    while (!out_valid && lat < TIMEOUT) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic release_result();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  vec_t vecs[$];
  int   lat;

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    op = '0; a = '0; b = '0; tag_in = '0;

    vecs.push_back('{"mul_neg",     3'b000, 32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB});
    vecs.push_back('{"mulh_min",    3'b001, 32'h8000_0000,  32'h8000_0000, 5'd1,  32'h4000_0000});
    vecs.push_back('{"mulhu_max",   3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd2,  32'hFFFF_FFFE});
    vecs.push_back('{"mulhsu",      3'b010, 32'hFFFF_FFFF,  32'd2,         5'd3,  32'hFFFF_FFFF});
    vecs.push_back('{"divu",        3'b101, 32'd100,        32'd7,         5'd4,  32'd14});
    vecs.push_back('{"remu",        3'b111, 32'd100,        32'd7,         5'd6,  32'd2});
    vecs.push_back('{"div_neg",     3'b100, 32'hFFFF_FFF9,  32'd2,         5'd7,  32'hFFFF_FFFD});
    vecs.push_back('{"rem_neg",     3'b110, 32'hFFFF_FFF9,  32'd2,         5'd8,  32'hFFFF_FFFF});
    vecs.push_back('{"div_by0",     3'b100, 32'd1234,       32'd0,         5'd9,  32'hFFFF_FFFF});
    vecs.push_back('{"rem_by0",     3'b110, 32'd1234,       32'd0,         5'd10, 32'd1234});
    vecs.push_back('{"div_neg_by0", 3'b100, 32'hFFFF_FFFB,  32'd0,         5'd11, 32'hFFFF_FFFF});
    vecs.push_back('{"remu_by0",    3'b111, 32'hDEAD_BEEF,  32'd0,         5'd12, 32'hDEAD_BEEF});
    vecs.push_back('{"div_ovf",     3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 5'd13, 32'h8000_0000});
    vecs.push_back('{"rem_ovf",     3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 5'd14, 32'd0});
    vecs.push_back('{"rem_min_3",   3'b110, 32'h8000_0000,  32'd3,         5'd15, 32'hFFFF_FFFE});
    vecs.push_back('{"mul_big",     3'b000, 32'h0001_0001,  32'h0001_0001, 5'd31, 32'h0002_0001});

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready",  64'(in_ready),  64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy",      64'(busy),      64'd0);
    check("rst_result",    64'(result),    64'd0);
    check("rst_tag_out",   64'(tag_out),   64'd0);
    @(negedge clk);
    reset = 1'b0;

    // Table of directed vectors.
    for (int i = 0; i < vecs.size(); i++) begin
      start_and_wait(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag, lat);
      check({vecs[i].name, "_latency"}, 64'(lat),     64'(LATENCY));
      check({vecs[i].name, "_result"},  64'(result),  64'(vecs[i].exp));
      check({vecs[i].name, "_tag"},     64'(tag_out), 64'(vecs[i].tag));
      release_result();
      check({vecs[i].name, "_idle"},    64'(in_ready), 64'd1);
    end

    // Backpressure: result held in DONE, new requests refused.
    start_and_wait(3'b101, 32'd1000, 32'd10, 5'd21, lat);
    check("bp_latency", 64'(lat), 64'(LATENCY));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1; op = 3'b000; a = 32'd9; b = 32'd9; tag_in = 5'd3;
      @(posedge clk); #1;
      check("bp_result",    64'(result),    64'd100);
      check("bp_tag",       64'(tag_out),   64'd21);
      check("bp_in_ready",  64'(in_ready),  64'd0);
      check("bp_out_valid", 64'(out_valid), 64'd1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_rel_in_ready",  64'(in_ready),  64'd1);
    check("bp_rel_out_valid", 64'(out_valid), 64'd0);
    check("bp_rel_busy",      64'(busy),      64'd0);
    @(posedge clk); #1;
    check("bp_no_accept", 64'(busy), 64'd0);

    // out_ready while idle has no effect.
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("idle_ready_busy",   64'(busy),   64'd0);
    check("idle_ready_result", 64'(result), 64'd100);

    // Reset in the middle of CALC aborts the operation.
    @(negedge clk);
    in_valid = 1'b1; op = 3'b000; a = 32'd5; b = 32'd6; tag_in = 5'd17;
    @(posedge clk); #1;                 // accept -> PREP
    in_valid = 1'b0;
    repeat (11) @(posedge clk);         // PREP -> CALC, then CALC cycles 0..9
    #1;
    check("mid_busy", 64'(busy), 64'd1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("abort_in_ready",  64'(in_ready),  64'd1);
    check("abort_busy",      64'(busy),      64'd0);
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_result",    64'(result),    64'd0);
    check("abort_tag",       64'(tag_out),   64'd0);
    @(negedge clk);
    reset = 1'b0;

    start_and_wait(3'b000, 32'd3, 32'd4, 5'd8, lat);
    check("post_rst_latency", 64'(lat),     64'(LATENCY));
    check("post_rst_result",  64'(result),  64'd12);
    check("post_rst_tag",     64'(tag_out), 64'd8);
    release_result();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
